ext_int_arbiter: RTL
====================

// Module: ext_int_arbiter
// PURPOSE
// Priority arbiter between the external interrupt sources and the core. Per-source enable and priority,
// global threshold, claim/complete handshake. A sequential scanner sweeps one source per cycle; the
// winning source drives ext_int_trigger. Sits on the peripheral bus beside the external interrupt
// controller and uses the same slave protocol.
// PARAMETERS
// SRC_NUM   8   number of interrupt sources; SRC_NUM*PRIO_W <= 32
// PRIO_W    2   priority field width per source; priority 0 = source never wins
// VA_WIDTH  5   bus address width (byte address)
// PORTS
// clk             in   1         clock
// rst             in   1         synchronous reset, active-high
// int_pend        in   SRC_NUM   level pending per source, held high until serviced
// ext_int_trigger out  1         interrupt request to core
// addr            in   VA_WIDTH  byte address
// w_rb            in   1         1 = write, 0 = read
// acc             in   BUS_ACC_WIDTH  access size; only BUS_ACC_4B is legal
// rdata           out  32        read data, registered
// wdata           in   32        write data
// req             in   1         bus request, one-cycle pulse per access
// resp            out  1         access done, one cycle after a legal req
// fault           out  1         combinational, = req & invalid
// BEHAVIOUR
// - Register map (word offsets):
//   0x00 PENDING RO = int_pend & ~insvc
//   0x04 ENABLE  RW, reset 0
//   0x08 PRIO    RW, source i at bits [i*PRIO_W +: PRIO_W], reset 0
//   0x0C THRESH  RW, low PRIO_W bits, reset 0
//   0x10 CLAIM   read = claim, write = complete
// - Invalid access: acc != 4B, addr > 0x10, or a write to PENDING. Effect: fault=1 that cycle,
//   no resp, no state change.
// - Legal access: resp=1 in the next cycle. Read data is registered into rdata on the same edge.
//   Unused rdata bits read 0.
// - Define elig = int_pend & ENABLE & ~insvc. insvc is the in-service vector, reset 0.
// - Scanner FSM:
//   IDLE: result invalid. If |elig, then idx<=0, best_prio<=0, go to SCAN.
//   SCAN: each cycle examines source idx. If elig[idx] and prio[idx] > best_prio, record idx and its
//     priority as best. Strict > means the lowest index wins ties. When idx == SRC_NUM-1, go to COMMIT.
//   COMMIT: res_id <= best id; res_prio <= best_prio; res_vld <= (best_prio != 0). Then go to SCAN
//     with idx=0 if |elig, else go to IDLE.
//   Sweep latency is SRC_NUM+1 cycles from entering SCAN to res_vld being valid.
// - Restart events: a legal write to ENABLE or PRIO, or any legal CLAIM read. Each one clears res_vld
//   and forces SCAN with idx=0 and best_prio=0 next cycle, or IDLE if ~|elig. A restart overrides
//   COMMIT in the same cycle.
// - ext_int_trigger = res_vld & (res_prio > THRESH) & elig[res_id]. It is combinational and 0 at reset.
// - CLAIM read: if the trigger condition holds, return res_id+1 and set insvc[res_id]. Otherwise
//   return 0 and change nothing.
// - CLAIM write (complete): let n = wdata. If 1 <= n <= SRC_NUM, clear insvc[n-1]. Other values are
//   ignored silently (no fault). Completing a source that is not in service is a no-op.
//   A complete causes no restart; the next sweep picks the source up.
// - An int_pend drop mid-sweep can leave the result stale. The elig term in the trigger and claim
//   masks it, and the next sweep corrects it.
// - THRESH changes take effect combinationally on the trigger, with no rescan.
// - rst mid-sweep: FSM goes to IDLE; ENABLE, PRIO, THRESH, insvc, res_vld, rdata and resp go to 0.
// TESTING
// (SRC_NUM=8, PRIO_W=2)
// 1. Reset; int_pend=8'h04, ENABLE=0 -> trigger stays 0. PENDING reads 0x04. CLAIM reads 0.
// 2. ENABLE=0x04, PRIO src2=3 -> trigger within 9 cycles. CLAIM reads 3, then trigger=0 and
//    PENDING=0. Write CLAIM=3 -> trigger returns within 10 cycles.
// 3. Tie: src1 and src5 at prio 2, both enabled and pending -> CLAIM=2. After complete with src1 still
//    pending, CLAIM=2 again. With src1 released, CLAIM=6.
// 4. Threshold: src4 at prio 1, THRESH=1 -> no trigger. THRESH=0 -> trigger the next cycle.
// 5. Faults: acc=2B read, addr=0x14, write to 0x00 -> fault=1, no resp, registers unchanged.
//    Complete with 0 or 9 -> no fault, no change.
// 6. Assert rst while src7 is pending mid-SCAN -> all outputs 0. ENABLE must be rewritten before any
//    trigger.

Source files
------------

// File: rtl/ext_int_arbiter.sv
// ---------------------------------------------------------------------------
// ext_int_arbiter
//
// Priority arbiter between the external interrupt sources and the core.
// Each source has an enable bit and a PRIO_W-bit priority. A global
// threshold gates the request. A claim/complete handshake on the peripheral
// bus marks sources in service. A sequential scanner looks at one source per
// cycle. The winner of a sweep drives ext_int_trigger.
//
// Register map (byte addresses, 32-bit words):
//   0x00 PENDING  RO  int_pend & ~insvc
//   0x04 ENABLE   RW  per-source enable
//   0x08 PRIO     RW  source i at bits [i*PRIO_W +: PRIO_W]
//   0x0C THRESH   RW  low PRIO_W bits
//   0x10 CLAIM    read = claim (id+1 or 0), write = complete (id+1)
//
// Ports:
//   clk             clock
//   rst             synchronous reset, active-high
//   int_pend        level-sensitive pending flag per source
//   ext_int_trigger interrupt request to the core (combinational)
//   addr            bus byte address
//   w_rb            1 = write, 0 = read
//   acc             access size; only BUS_ACC_4B is legal
//   rdata           registered read data
//   wdata           write data
//   req             bus request, one-cycle pulse per access
//   resp            access done, one cycle after a legal req
//   fault           combinational, req & invalid access
// ---------------------------------------------------------------------------
module ext_int_arbiter #(
  parameter int                       SRC_NUM       = 8,
  parameter int                       PRIO_W        = 2,
  parameter int                       VA_WIDTH      = 5,
  parameter int                       BUS_ACC_WIDTH = 2,
  parameter logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B    = BUS_ACC_WIDTH'(2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SRC_NUM-1:0]       int_pend,
  output logic                     ext_int_trigger,
  input  logic [VA_WIDTH-1:0]      addr,
  input  logic                     w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] acc,
  output logic [31:0]              rdata,
  input  logic [31:0]              wdata,
  input  logic                     req,
  output logic                     resp,
  output logic                     fault
);

  localparam int IDX_W = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
  localparam int PW    = SRC_NUM * PRIO_W;
  localparam int WW    = VA_WIDTH - 2;

  localparam logic [WW-1:0] W_PENDING = WW'(0);
  localparam logic [WW-1:0] W_ENABLE  = WW'(1);
  localparam logic [WW-1:0] W_PRIO    = WW'(2);
  localparam logic [WW-1:0] W_THRESH  = WW'(3);
  localparam logic [WW-1:0] W_CLAIM   = WW'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_COMMIT
  } state_e;

  // Programmable state
  logic [SRC_NUM-1:0] enable_q;
  logic [PW-1:0]      prio_q;
  logic [PRIO_W-1:0]  thresh_q;
  logic [SRC_NUM-1:0] insvc_q, insvc_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               resp_q;

  // Scanner state
  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   best_id_q;
  logic [PRIO_W-1:0]  best_prio_q;
  logic [IDX_W-1:0]   res_id_q;
  logic [PRIO_W-1:0]  res_prio_q;
  logic               res_vld_q;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic [WW-1:0] word;
  logic          invalid, legal;
  logic          wr_enable, wr_prio, wr_thresh, claim_rd, complete_wr;
  logic          cmpl_ok;

  assign word    = addr[VA_WIDTH-1:2];
  assign invalid = (acc != BUS_ACC_4B) || (addr > VA_WIDTH'(16)) ||
                   (w_rb && (word == W_PENDING));
  assign legal   = req & ~invalid;
  assign fault   = req & invalid;

  assign wr_enable   = legal &  w_rb & (word == W_ENABLE);
  assign wr_prio     = legal &  w_rb & (word == W_PRIO);
  assign wr_thresh   = legal &  w_rb & (word == W_THRESH);
  assign complete_wr = legal &  w_rb & (word == W_CLAIM);
  assign claim_rd    = legal & ~w_rb & (word == W_CLAIM);

  // Complete ids outside 1..SRC_NUM are dropped without a fault.
  assign cmpl_ok = (wdata >= 32'd1) && (wdata <= 32'(SRC_NUM));

  // -------------------------------------------------------------------------
  // Eligibility and trigger
  // -------------------------------------------------------------------------
  logic [SRC_NUM-1:0] elig;
  logic               any_elig;
  logic [PRIO_W-1:0]  cur_prio;
  logic               restart;

  assign elig     = int_pend & enable_q & ~insvc_q;
  assign any_elig = |elig;
  assign cur_prio = prio_q[idx_q*PRIO_W +: PRIO_W];

  // The elig term masks a result that went stale because its source dropped
  // or was claimed after the sweep examined it.
  assign ext_int_trigger = res_vld_q && (res_prio_q > thresh_q) && elig[res_id_q];

  // Anything that can change the winner, or takes the current one, restarts
  // the sweep from source 0.
  assign restart = wr_enable | wr_prio | claim_rd;

  // -------------------------------------------------------------------------
  // Next-state for in-service vector and read data
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    insvc_d = insvc_q;
    if (claim_rd && ext_int_trigger) insvc_d[res_id_q] = 1'b1;
    // For a power-of-two SRC_NUM, id SRC_NUM has zero low bits and wraps to
    // SRC_NUM-1 after the decrement, which is the intended index.
    if (complete_wr && cmpl_ok) insvc_d[wdata[IDX_W-1:0] - 1'b1] = 1'b0;
  end

  always_comb begin
    rdata_d = '0;
    case (word)
      W_PENDING: rdata_d = 32'(int_pend & ~insvc_q);
      W_ENABLE:  rdata_d = 32'(enable_q);
      W_PRIO:    rdata_d = 32'(prio_q);
      W_THRESH:  rdata_d = 32'(thresh_q);
      W_CLAIM:   rdata_d = ext_int_trigger ? (32'(res_id_q) + 32'd1) : 32'd0;
      default:   rdata_d = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Bus-visible registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= '0;
      prio_q   <= '0;
      thresh_q <= '0;
      insvc_q  <= '0;
      rdata_q  <= '0;
      resp_q   <= 1'b0;
    end else begin
      resp_q  <= legal;
      insvc_q <= insvc_d;
      if (legal && !w_rb) rdata_q  <= rdata_d;
      if (wr_enable)      enable_q <= wdata[SRC_NUM-1:0];
      if (wr_prio)        prio_q   <= wdata[PW-1:0];
      if (wr_thresh)      thresh_q <= wdata[PRIO_W-1:0];
    end
  end

  assign rdata = rdata_q;
  assign resp  = resp_q;

  // -------------------------------------------------------------------------
  // Scanner FSM: one source per cycle, then a commit cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      res_id_q    <= '0;
      res_prio_q  <= '0;
      res_vld_q   <= 1'b0;
    end else if (restart) begin
      // Restart wins over a COMMIT in the same cycle.
      res_vld_q   <= 1'b0;
      idx_q       <= '0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      state_q     <= any_elig ? S_SCAN : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          res_vld_q <= 1'b0;
          if (any_elig) begin
            idx_q       <= '0;
            best_id_q   <= '0;
            best_prio_q <= '0;
            state_q     <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Strict compare keeps the lowest index on a priority tie.
          if (elig[idx_q] && (cur_prio > best_prio_q)) begin
            best_id_q   <= idx_q;
            best_prio_q <= cur_prio;
          end
          if (idx_q == IDX_W'(SRC_NUM - 1)) begin
            state_q <= S_COMMIT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_COMMIT: begin
          res_id_q    <= best_id_q;
          res_prio_q  <= best_prio_q;
          res_vld_q   <= (best_prio_q != '0);
          idx_q       <= '0;
          best_id_q   <= '0;
          best_prio_q <= '0;
          state_q     <= any_elig ? S_SCAN : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
